// File: rtl/key_event_scheduler.sv
// key_event_scheduler
//   Debounces four active-low keys and turns each accepted press into a key id.
//   Presses first set a per-key pending bit. A round-robin arbiter then moves
//   pending keys into a 4-entry event FIFO. The FIFO is read over an Avalon-MM
//   slave, and a level interrupt is raised while events or an overflow exist.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   address     Avalon-MM word address (0: event pop, 1: status, 2: irq enable,
//               3: control)
//   chipselect  slave select
//   read        read strobe, active high
//   write_n     write strobe, active low
//   writedata   write data
//   in_port     raw asynchronous keys, active low (pressed = 0)
//   readdata    registered read data, valid one cycle after the read
//   irq         irq_enable & (FIFO non-empty | overflow)
module key_event_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic [3:0]  in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  sync1, sync2, stable, stable_prev;
  logic [15:0] cnt [4];
  logic [3:0]  pending;
  logic        overflow, irq_enable;
  logic [1:0]  last_grant;
  logic [1:0]  fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;

  logic        wr_en, rd_en, flush, ovf_clear, ovf_set;
  logic        fifo_empty, fifo_full, push, pop;
  logic [3:0]  press, grant_onehot;
  logic        grant_valid;
  logic [1:0]  grant_id, cand;

  assign wr_en      = chipselect & ~write_n;
  assign rd_en      = chipselect & read;
  assign flush      = wr_en && (address == 2'd3) && writedata[1];
  assign ovf_clear  = wr_en && (address == 2'd3) && writedata[0];
  assign fifo_empty = (count == 3'd0);
  assign fifo_full  = (count == 3'd4);

  // A falling edge of the debounced level is a press; releases are ignored.
  assign press = stable_prev & ~stable;

  // Round-robin search starting one past the previous winner.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = last_grant;
    cand        = last_grant;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!grant_valid && pending[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Arbitration looks at the registered count, so a pop at full frees a slot
  // for the following cycle. A flush discards whatever would be granted.
  assign push         = grant_valid & ~fifo_full & ~flush;
  assign grant_onehot = push ? (4'b0001 << grant_id) : 4'b0000;
  assign pop          = rd_en && (address == 2'd0) && !fifo_empty && !flush;

  // Only a press that lands on a pending bit that is not being granted in the
  // same cycle counts as lost; press-and-grant leaves the bit set instead.
  assign ovf_set = |(press & pending & ~grant_onehot) & ~flush;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= 4'b1111;
      sync2       <= 4'b1111;
      stable      <= 4'b1111;
      stable_prev <= 4'b1111;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1       <= in_port;
      sync2       <= sync1;
      stable_prev <= stable;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != stable[i]) begin
          if (cnt[i] == CNT_LAST) begin
            stable[i] <= sync2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + 16'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      overflow   <= 1'b0;
      irq_enable <= 1'b0;
      last_grant <= 2'd3;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (flush) begin
        pending <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
      end else begin
        pending <= (pending & ~grant_onehot) | press;
        if (push) begin
          wr_ptr     <= wr_ptr + 2'd1;
          last_grant <= grant_id;
        end
        if (pop) rd_ptr <= rd_ptr + 2'd1;
        count <= count + {2'b00, push} - {2'b00, pop};
      end
      if (ovf_set)        overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
      if (wr_en && address == 2'd2) irq_enable <= writedata[0];
    end
  end

  // NOTE: FIFO storage is left unreset; entries are only observed through
  // count, which is reset, so the payload never needs clearing.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= grant_id;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd_en) begin
      unique case (address)
        2'd0:    readdata <= {23'd0, !fifo_empty, 6'd0,
                              fifo_empty ? 2'd0 : fifo_mem[rd_ptr]};
        2'd1:    readdata <= {24'd0, pending, overflow, count};
        2'd2:    readdata <= {31'd0, irq_enable};
        default: readdata <= '0;
      endcase
    end
  end

  assign irq = irq_enable & (!fifo_empty | overflow);

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler with DEBOUNCE_CYCLES = 16.
// Press latency from in_port falling to the FIFO push is 20 clock edges:
// 2 synchronizer edges, 16 debounce edges, 1 edge to pending, 1 to grant.
module tb_key_event_scheduler;

  localparam int unsigned D = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect, read, write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  key_event_scheduler #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] data);
    address    = a;
    chipselect = 1'b1;
    read       = 1'b1;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read       = 1'b0;
    data       = readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] data);
    address    = a;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Hold a key pattern low long enough to be accepted, then release and let
  // the release debounce out.
  task automatic press_keys(input logic [3:0] pattern);
    in_port = pattern;
    tick(D + 4);
    in_port = 4'b1111;
    tick(D + 24);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    read       = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'b1111;
    tick(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    reset = 1'b0;
    tick(2);
    bus_read(2'd1, rd); check("reset_status", rd, 32'h0);

    // Single press of key 2 yields exactly one event.
    press_keys(4'b1011);
    bus_read(2'd0, rd); check("key2_pop", rd, 32'h102);
    bus_read(2'd0, rd); check("key2_empty", rd, 32'h000);

    // Key 1 bouncing faster than the debounce window produces nothing.
    reset_pulse();
    for (int n = 0; n < 6; n++) begin
      in_port = 4'b1101; tick(5);
      in_port = 4'b1111; tick(5);
    end
    tick(D + 24);
    bus_read(2'd1, rd); check("bounce_status", rd, 32'h0);

    // All keys at once: FIFO fills 0,1,2,3 and pending drains.
    reset_pulse();
    press_keys(4'b0000);
    bus_read(2'd1, rd); check("all_status", rd, 32'h4);

    // Two presses of key 0 against a full FIFO: pending held, overflow set.
    press_keys(4'b1110);
    press_keys(4'b1110);
    bus_read(2'd1, rd); check("ovf_status", rd, 32'h1C);
    bus_write(2'd2, 32'h1);
    check("ovf_irq", {31'd0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    bus_read(2'd1, rd); check("ovf_cleared", rd, 32'h14);

    // Pop at full: slot reopens and held key 0 is granted next cycle.
    bus_read(2'd0, rd); check("full_pop0", rd, 32'h100);
    tick(1);
    bus_read(2'd1, rd); check("regrant_status", rd, 32'h04);
    bus_read(2'd0, rd); check("pop1", rd, 32'h101);
    bus_read(2'd0, rd); check("pop2", rd, 32'h102);

    // At count 2, pop lands on the same edge as the key-1 push.
    in_port = 4'b1101;
    tick(D + 3);
    bus_read(2'd0, rd); check("simul_pop3", rd, 32'h103);
    bus_read(2'd1, rd); check("simul_count", rd, 32'h02);
    bus_read(2'd0, rd); check("order_key0", rd, 32'h100);
    bus_read(2'd0, rd); check("order_key1", rd, 32'h101);
    bus_read(2'd0, rd); check("order_empty", rd, 32'h000);
    in_port = 4'b1111;
    tick(D + 24);
    check("drained_irq", {31'd0, irq}, 32'h0);

    // Reset while three events are queued clears outputs immediately.
    press_keys(4'b1000);
    check("queued_irq", {31'd0, irq}, 32'h1);
    bus_read(2'd1, rd); check("queued_status", rd, 32'h3);
    #2;
    reset = 1'b1;
    #1;
    check("async_readdata", readdata, 32'h0);
    check("async_irq", {31'd0, irq}, 32'h0);
    tick(2);
    reset = 1'b0;
    tick(1);
    bus_read(2'd1, rd); check("post_reset_status", rd, 32'h0);
    bus_read(2'd2, rd); check("post_reset_enable", rd, 32'h0);

    // Reset in the middle of debouncing key 3 leaves no event behind.
    in_port = 4'b0111;
    tick(10);
    reset   = 1'b1;
    in_port = 4'b1111;
    tick(2);
    reset = 1'b0;
    tick(D + 24);
    bus_read(2'd1, rd); check("mid_debounce_status", rd, 32'h0);

    // Writes to addresses 0/1 are ignored; flush empties FIFO.
    bus_write(2'd2, 32'h1);
    press_keys(4'b1100);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd1, rd); check("ignored_writes", rd, 32'h2);
    bus_read(2'd2, rd); check("enable_read", rd, 32'h1);
    bus_read(2'd3, rd); check("ctrl_read", rd, 32'h0);
    bus_write(2'd3, 32'h2);
    bus_read(2'd1, rd); check("flush_status", rd, 32'h0);
    check("flush_irq", {31'd0, irq}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
